// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_controller
// Description : Turns the divided slow-clock level into one-cycle processor
//               clock enables (free-run mode), or issues one enable per
//               debounced button press (single-step mode). Freezes the
//               processor on halt until reset, and counts issued steps.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   slow_tick_in,
  input  logic                   step_button,
  input  logic                   run_mode,
  input  logic                   halt,
  output logic                   cpu_enable,
  output logic                   halted,
  output logic                   button_level,
  output logic [COUNT_WIDTH-1:0] step_count
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1; keep at least 1 bit.
  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Synchronizer and edge-detect registers
  logic tick_s1_q, tick_s1_d;
  logic tick_s2_q, tick_s2_d;
  logic tick_prev_q, tick_prev_d;
  logic btn_s1_q, btn_s1_d;
  logic btn_s2_q, btn_s2_d;

  // Debounce registers
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            button_level_q, button_level_d;
  logic            button_prev_q, button_prev_d;

  // Post-reset tick mask: a level already high at release must not pulse
  logic [1:0] mask_cnt_q, mask_cnt_d;

  // Controller registers
  state_t                 state_q, state_d;
  logic                   cpu_enable_q, cpu_enable_d;
  logic                   halted_q, halted_d;
  logic [COUNT_WIDTH-1:0] step_count_q, step_count_d;

  logic tick_event;
  logic press_event;

  // Synchronizer chains, tick delay and post-reset mask counter
  always_comb begin
    tick_s1_d   = slow_tick_in;
    tick_s2_d   = tick_s1_q;
    tick_prev_d = tick_s2_q;
    btn_s1_d    = step_button;
    btn_s2_d    = btn_s1_q;
    mask_cnt_d  = (mask_cnt_q == 2'd3) ? mask_cnt_q : (mask_cnt_q + 2'd1);
  end

  // Rising-edge events; ticks are ignored until the mask has expired
  always_comb begin
    tick_event  = tick_s2_q & ~tick_prev_q & (mask_cnt_q == 2'd3);
    press_event = button_level_q & ~button_prev_q;
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    db_cnt_d       = db_cnt_q;
    button_level_d = button_level_q;
    button_prev_d  = button_level_q;
    if (btn_s2_q == button_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d       = '0;
      button_level_d = ~button_level_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Mode FSM next-state, enable pulse generation and step counting
  always_comb begin
    state_d      = state_q;
    cpu_enable_d = 1'b0;
    step_count_d = step_count_q;
    case (state_q)
      ST_STEP: begin
        if (halt) begin
          state_d = ST_HALT;
        end else begin
          cpu_enable_d = press_event;
          if (run_mode) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end else begin
          cpu_enable_d = tick_event;
          if (!run_mode) begin
            state_d = ST_STEP;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_STEP;
      end
    endcase
    if (cpu_enable_d) begin
      step_count_d = step_count_q + COUNT_WIDTH'(1);
    end
    halted_d = (state_d == ST_HALT);
  end

  // Synchronizer, debounce and mask registers
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_s1_q      <= 1'b0;
      tick_s2_q      <= 1'b0;
      tick_prev_q    <= 1'b0;
      btn_s1_q       <= 1'b0;
      btn_s2_q       <= 1'b0;
      db_cnt_q       <= '0;
      button_level_q <= 1'b0;
      button_prev_q  <= 1'b0;
      mask_cnt_q     <= 2'd0;
    end else begin
      tick_s1_q      <= tick_s1_d;
      tick_s2_q      <= tick_s2_d;
      tick_prev_q    <= tick_prev_d;
      btn_s1_q       <= btn_s1_d;
      btn_s2_q       <= btn_s2_d;
      db_cnt_q       <= db_cnt_d;
      button_level_q <= button_level_d;
      button_prev_q  <= button_prev_d;
      mask_cnt_q     <= mask_cnt_d;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_STEP;
      cpu_enable_q <= 1'b0;
      halted_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cpu_enable_q <= cpu_enable_d;
      halted_q     <= halted_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_enable   = cpu_enable_q;
  assign halted       = halted_q;
  assign button_level = button_level_q;
  assign step_count   = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_step_controller
// Description : Directed bench for cpu_step_controller. A 32-bit counter
//               instance and a 4-bit counter instance share all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_step_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        slow_tick_in = 1'b0;
  logic        step_button = 1'b0;
  logic        run_mode = 1'b0;
  logic        halt = 1'b0;
  logic        cpu_enable, halted, button_level;
  logic [31:0] step_count;
  logic        cpu_enable4, halted4, button_level4;
  logic [3:0]  step_count4;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int consec = 0;
  int lockstep = 0;
  bit prev_en = 1'b0;

  cpu_step_controller #(.DEBOUNCE_CYCLES(20), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .slow_tick_in(slow_tick_in),
    .step_button(step_button), .run_mode(run_mode), .halt(halt),
    .cpu_enable(cpu_enable), .halted(halted), .button_level(button_level),
    .step_count(step_count)
  );

  cpu_step_controller #(.DEBOUNCE_CYCLES(20), .COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .slow_tick_in(slow_tick_in),
    .step_button(step_button), .run_mode(run_mode), .halt(halt),
    .cpu_enable(cpu_enable4), .halted(halted4), .button_level(button_level4),
    .step_count(step_count4)
  );

  always #5 clock = ~clock;

  // Advance one clock, sampling on the falling edge
  task automatic cyc();
    @(negedge clock);
    if (cpu_enable === 1'b1) begin
      pulses++;
      if (prev_en) consec++;
    end
    prev_en = (cpu_enable === 1'b1);
    if (cpu_enable4 !== cpu_enable || halted4 !== halted || button_level4 !== button_level)
      lockstep++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_cpu_enable: got %b want 0", cpu_enable); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (button_level !== 1'b0) begin errors++; $display("FAIL reset_button_level: got %b want 0", button_level); end
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL reset_step_count: got %0d want 0", step_count); end
    reset = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic test_run_ticks();
    logic [5:0] obs;
    run_mode = 1'b1;
    repeat (2) cyc();
    for (int e = 0; e < 4; e++) begin
      slow_tick_in = 1'b1;
      for (int i = 0; i < 6; i++) begin cyc(); obs[i] = cpu_enable; end
      checks++; if (obs !== 6'b000100) begin errors++; $display("FAIL run_rise_latency[%0d]: got %b want 000100", e, obs); end
      slow_tick_in = 1'b0;
      for (int i = 0; i < 6; i++) begin cyc(); obs[i] = cpu_enable; end
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL run_fall_nopulse[%0d]: got %b want 000000", e, obs); end
    end
    checks++; if (step_count !== 32'd4) begin errors++; $display("FAIL run_step_count: got %0d want 4", step_count); end
  endtask

  task automatic test_debounce();
    int p0;
    int first;
    logic lvl21, lvl22;
    run_mode = 1'b0;
    repeat (2) cyc();
    p0 = pulses;
    first = -1;
    for (int s = 0; s < 4; s++) begin
      step_button = (s % 2 == 0) ? 1'b1 : 1'b0;
      repeat (3) cyc();
    end
    step_button = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      cyc();
      if (i == 21) lvl21 = button_level;
      if (i == 22) lvl22 = button_level;
      if (cpu_enable === 1'b1 && first < 0) first = i;
    end
    checks++; if (lvl21 !== 1'b0) begin errors++; $display("FAIL debounce_early: level got %b want 0", lvl21); end
    checks++; if (lvl22 !== 1'b1) begin errors++; $display("FAIL debounce_accept: level got %b want 1", lvl22); end
    checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL press_pulse_count: got %0d want 1", pulses - p0); end
    checks++; if (first != 23) begin errors++; $display("FAIL press_pulse_cycle: got %0d want 23", first); end
    p0 = pulses;
    step_button = 1'b0;
    repeat (30) cyc();
    checks++; if (button_level !== 1'b0) begin errors++; $display("FAIL release_level: got %b want 0", button_level); end
    checks++; if (pulses != p0) begin errors++; $display("FAIL release_nopulse: got %0d pulses want 0", pulses - p0); end
    checks++; if (step_count !== 32'd5) begin errors++; $display("FAIL press_step_count: got %0d want 5", step_count); end
  endtask

  task automatic test_halt();
    int p0;
    run_mode = 1'b1;
    repeat (2) cyc();
    p0 = pulses;
    slow_tick_in = 1'b1;
    cyc(); cyc();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL halt_wins: cpu_enable got %b want 0", cpu_enable); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: halted got %b want 1", halted); end
    repeat (5) cyc();
    slow_tick_in = 1'b0; repeat (6) cyc();
    slow_tick_in = 1'b1; repeat (6) cyc();
    slow_tick_in = 1'b0;
    run_mode = 1'b0;
    step_button = 1'b1; repeat (25) cyc();
    step_button = 1'b0; repeat (25) cyc();
    checks++; if (pulses != p0) begin errors++; $display("FAIL halt_frozen: got %0d pulses want 0", pulses - p0); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: halted got %b want 1", halted); end
    checks++; if (step_count !== 32'd5) begin errors++; $display("FAIL halt_count_hold: got %0d want 5", step_count); end
    reset = 1'b1;
    cyc(); cyc();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: halted got %b want 0", halted); end
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL halt_reset_count: got %0d want 0", step_count); end
    reset = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic test_mode_change();
    int p0;
    do_reset();
    run_mode = 1'b1;
    repeat (2) cyc();
    slow_tick_in = 1'b1;
    cyc(); cyc();
    run_mode = 1'b0;
    cyc();
    checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL mode_fall_pulse: got %b want 1", cpu_enable); end
    checks++; if (step_count !== 32'd1) begin errors++; $display("FAIL mode_fall_count: got %0d want 1", step_count); end
    repeat (3) cyc();
    p0 = pulses;
    slow_tick_in = 1'b0; repeat (6) cyc();
    slow_tick_in = 1'b1; repeat (6) cyc();
    slow_tick_in = 1'b0; repeat (6) cyc();
    checks++; if (pulses != p0) begin errors++; $display("FAIL step_ignores_tick: got %0d pulses want 0", pulses - p0); end
  endtask

  task automatic test_wrap();
    do_reset();
    run_mode = 1'b1;
    repeat (2) cyc();
    for (int s = 1; s <= 17; s++) begin
      slow_tick_in = 1'b1;
      repeat (3) cyc();
      if (s == 15) begin
        checks++; if (step_count4 !== 4'd15) begin errors++; $display("FAIL wrap_at15: got %0d want 15", step_count4); end
      end
      if (s == 16) begin
        checks++; if (step_count4 !== 4'd0) begin errors++; $display("FAIL wrap_to0: got %0d want 0", step_count4); end
      end
      repeat (3) cyc();
      slow_tick_in = 1'b0;
      repeat (6) cyc();
    end
    checks++; if (step_count4 !== 4'd1) begin errors++; $display("FAIL wrap_end: got %0d want 1", step_count4); end
    checks++; if (step_count !== 32'd17) begin errors++; $display("FAIL wide_count: got %0d want 17", step_count); end
  endtask

  task automatic test_reset_tick_high();
    int p0;
    run_mode = 1'b1;
    slow_tick_in = 1'b1;
    reset = 1'b1;
    repeat (4) cyc();
    reset = 1'b0;
    p0 = pulses;
    repeat (20) cyc();
    checks++; if (pulses != p0) begin errors++; $display("FAIL held_tick_masked: got %0d pulses want 0", pulses - p0); end
    slow_tick_in = 1'b0;
    repeat (6) cyc();
    slow_tick_in = 1'b1;
    cyc(); cyc();
    checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL retick_early: got %b want 0", cpu_enable); end
    cyc();
    checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL retick_pulse: got %b want 1", cpu_enable); end
    checks++; if (step_count !== 32'd1) begin errors++; $display("FAIL retick_count: got %0d want 1", step_count); end
    repeat (4) cyc();
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_debounce();
    test_halt();
    test_mode_change();
    test_wrap();
    test_reset_tick_high();
    checks++; if (consec != 0) begin errors++; $display("FAIL consecutive_enable: got %0d want 0", consec); end
    checks++; if (lockstep != 0) begin errors++; $display("FAIL width_lockstep: got %0d diffs want 0", lockstep); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
